// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared receiver state encodings and default frame/baud constants
package uart_rx_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_e;
    localparam int DEF_DB      = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_DVSR    = 163;
    localparam int DEF_DVSR_W  = 8;
endpackage

// File: rtl/uart_rx_baud_gen.sv
// baud_gen: free-running divider producing a one-clk tick every DVSR cycles
module baud_gen #(
    parameter int DVSR   = 163,
    parameter int DVSR_W = 8
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = cnt_q == DVSR_W'(DVSR - 1);
        cnt_d = tick ? '0 : cnt_q + DVSR_W'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver with framing-error flag
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DB      = DEF_DB,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int DVSR    = DEF_DVSR,
    parameter int DVSR_W  = DEF_DVSR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic [DB-1:0] d_out,
    output logic          rx_done,
    output logic          frame_err
);
    // s must still count to 15 in DATA even when the stop period is short
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DB > 1) ? $clog2(DB) : 1;
    state_e        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [DB-1:0] b_q, b_d, d_out_q, d_out_d;
    logic          frame_err_q, frame_err_d, rx_done_q, rx_done_d;
    logic [1:0]    sync_q;
    logic          rx_s, tick;
    baud_gen #(.DVSR(DVSR), .DVSR_W(DVSR_W)) u_baud (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );
    assign rx_s      = sync_q[1];
    assign d_out     = d_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        d_out_d     = d_out_q;
        frame_err_d = frame_err_q;
        rx_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SW'(7)) begin
                        state_d = rx_s ? IDLE : DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else s_d = s_q + SW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        b_d     = {rx_s, b_q[DB-1:1]};
                        s_d     = '0;
                        state_d = (n_q == NW'(DB - 1)) ? STOP : DATA;
                        n_d     = n_q + NW'(1);
                    end else s_d = s_q + SW'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d     = IDLE;
                        d_out_d     = b_q;
                        frame_err_d = ~rx_s;
                        rx_done_d   = 1'b1;
                    end else s_d = s_q + SW'(1);
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            d_out_q     <= '0;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
            sync_q      <= 2'b11;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            d_out_q     <= d_out_d;
            frame_err_q <= frame_err_d;
            rx_done_q   <= rx_done_d;
            sync_q      <= {sync_q[0], rx};
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx at DVSR=4 (64 clk per bit)
module tb_uart_rx;
    import uart_rx_pkg::*;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done, frame_err;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] got[$];
    logic [7:0] prev_dout = '0;
    logic       prev_done = 1'b0;
    logic       chk_stab = 1'b0;
    int         unstable = 0;
    int         dbl = 0;
    uart_rx #(.DB(8), .SB_TICK(16), .DVSR(4), .DVSR_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .d_out    (d_out),
        .rx_done  (rx_done),
        .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rx_done) got.push_back({frame_err, d_out});
        if (rx_done && prev_done) dbl++;
        if (chk_stab && !rx_done && d_out !== prev_dout) unstable++;
        prev_done = rx_done;
        prev_dout = d_out;
    end
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask
    // A bad stop bit is held low through its sample point then released early,
    // so the receiver re-entering IDLE sees a false start rather than a new frame.
    task automatic send_frame(input logic [7:0] v, input int bc, input logic stop_ok);
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            repeat (bc) @(negedge clk);
        end
        rx = stop_ok;
        repeat (stop_ok ? bc : 48) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (bc - 48) @(negedge clk);
    endtask
    task automatic expect_one(input string nm, input logic [7:0] v, input logic fe);
        n_cmp++;
        if (got.size() !== 1) begin
            n_err++;
            $display("FAIL %s count: got %0d pulses, want 1", nm, got.size());
        end else begin
            n_cmp++;
            if (got[0][7:0] !== v) begin
                n_err++;
                $display("FAIL %s byte: got %h want %h", nm, got[0][7:0], v);
            end
            n_cmp++;
            if (got[0][8] !== fe) begin
                n_err++;
                $display("FAIL %s frame_err: got %b want %b", nm, got[0][8], fe);
            end
        end
        got.delete();
    endtask
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset rx_done: got %b want 0", rx_done); end
        n_cmp++; if (d_out !== 8'h00) begin n_err++; $display("FAIL reset d_out: got %h want 00", d_out); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL reset state: got %0d want 0", dut.state_q); end
        reset = 1'b0;
        idle(20);
        got.delete();
    endtask
    task automatic test_clean;
        send_frame(8'hA5, 64, 1'b1);
        idle(100);
        expect_one("clean", 8'hA5, 1'b0);
    endtask
    task automatic test_back_to_back;
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        chk_stab = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 64, 1'b1);
        idle(100);
        chk_stab = 1'b0;
        n_cmp++;
        if (got.size() !== 3) begin
            n_err++;
            $display("FAIL b2b count: got %0d pulses, want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got[i] !== {1'b0, exp_b[i]}) begin
                    n_err++;
                    $display("FAIL b2b frame%0d: got fe=%b %h want fe=0 %h", i, got[i][8], got[i][7:0], exp_b[i]);
                end
            end
        end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL b2b d_out stable: got %0d changes, want 0", unstable); end
        n_cmp++; if (dbl !== 0) begin n_err++; $display("FAIL b2b pulse width: got %0d long pulses, want 0", dbl); end
        got.delete();
    endtask
    task automatic test_false_start;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        idle(80);
        n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL false_start count: got %0d want 0", got.size()); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL false_start state: got %0d want 0", dut.state_q); end
        got.delete();
        send_frame(8'h5A, 64, 1'b1);
        idle(100);
        expect_one("after_false", 8'h5A, 1'b0);
    endtask
    task automatic test_frame_err;
        send_frame(8'h81, 64, 1'b0);
        idle(200);
        expect_one("frame_err", 8'h81, 1'b1);
        send_frame(8'h42, 64, 1'b1);
        idle(100);
        expect_one("ferr_clear", 8'h42, 1'b0);
    endtask
    task automatic test_reset_mid;
        logic [7:0] v;
        v = 8'hC3;
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = v[i];
            repeat (64) @(negedge clk);
        end
        rx = v[4];
        repeat (32) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(700);
        n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL reset_mid count: got %0d want 0", got.size()); end
        n_cmp++; if (d_out !== 8'h00) begin n_err++; $display("FAIL reset_mid d_out: got %h want 00", d_out); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_mid frame_err: got %b want 0", frame_err); end
        n_cmp++; if (rx_done !== 1'b0) begin n_err++; $display("FAIL reset_mid rx_done: got %b want 0", rx_done); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL reset_mid state: got %0d want 0", dut.state_q); end
        got.delete();
        send_frame(8'h96, 64, 1'b1);
        idle(100);
        expect_one("after_reset", 8'h96, 1'b0);
    endtask
    task automatic test_baud_tol;
        send_frame(8'h55, 66, 1'b1);
        idle(100);
        expect_one("baud_66", 8'h55, 1'b0);
    endtask
    initial begin
        test_reset();
        test_clean();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_reset_mid();
        test_baud_tol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
